// File: rtl/scoreboard_regfile_model.sv
// scoreboard_regfile_model: shadow register-file scoreboard checking the DUT's exported register array every cycle.
// Define SCB_REGFILE_ASSERT_EN to add concurrent assertions that flag mismatches as they occur.
module scoreboard_regfile_model #(
  parameter int NUM_REGS  = 32,
  parameter int XLEN      = 32,
  parameter int CMP_LAT   = 1,
  parameter int ERR_CNT_W = 16,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_chk_en,
  input  logic                          i_wr_en,
  input  logic [AW-1:0]                 i_wr_addr,
  input  logic [XLEN-1:0]               i_wr_data,
  input  logic [NUM_REGS-1:0][XLEN-1:0] drv_regs,
  output logic                          o_err_flag,
  output logic [ERR_CNT_W-1:0]          o_err_cnt,
  output logic [ERR_CNT_W-1:0]          o_chk_cnt,
  output logic [AW-1:0]                 o_first_err_idx,
  output logic [XLEN-1:0]               o_first_err_exp,
  output logic [XLEN-1:0]               o_first_err_act
);
  localparam int WW = $clog2(CMP_LAT + 1);
  typedef enum logic [1:0] {WARMUP, CHECK, FAIL} state_t;
  state_t                        state_q, state_d;
  logic [WW-1:0]                 wcnt_q, wcnt_d;
  logic [NUM_REGS-1:0][XLEN-1:0] shadow_q;
  logic                          err_flag_q, err_flag_d;
  logic [ERR_CNT_W-1:0]          err_cnt_q, err_cnt_d, chk_cnt_q, chk_cnt_d;
  logic [AW-1:0]                 idx_q, idx_d;
  logic [XLEN-1:0]               exp_q, exp_d, act_q, act_d;
  logic                          w_v;
  logic [AW-1:0]                 w_a;
  logic [XLEN-1:0]               w_d;
  logic                          mm_any;
  logic [AW-1:0]                 mm_idx;
  logic [XLEN-1:0]               mm_exp, mm_act;

  // Writes reach the shadow CMP_LAT-1 edges after sampling, in step with the DUT array.
  generate
    if (CMP_LAT == 1) begin : g_nodly
      assign w_v = i_wr_en;
      assign w_a = i_wr_addr;
      assign w_d = i_wr_data;
    end else begin : g_dly
      logic [CMP_LAT-2:0]           v_q;
      logic [CMP_LAT-2:0][AW-1:0]   a_q;
      logic [CMP_LAT-2:0][XLEN-1:0] d_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          v_q <= '0;
          a_q <= '0;
          d_q <= '0;
        end else begin
          v_q[0] <= i_wr_en;
          a_q[0] <= i_wr_addr;
          d_q[0] <= i_wr_data;
          for (int k = CMP_LAT - 2; k > 0; k--) begin
            v_q[k] <= v_q[k-1];
            a_q[k] <= a_q[k-1];
            d_q[k] <= d_q[k-1];
          end
        end
      end
      assign w_v = v_q[CMP_LAT-2];
      assign w_a = a_q[CMP_LAT-2];
      assign w_d = d_q[CMP_LAT-2];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) shadow_q <= '0;
    else if (w_v && w_a != '0 && int'(w_a) < NUM_REGS) shadow_q[w_a] <= w_d;
  end

  // Descending scan leaves the lowest mismatching index in mm_idx.
  always_comb begin
    mm_any = 1'b0;
    mm_idx = '0;
    mm_exp = '0;
    mm_act = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (shadow_q[i] != drv_regs[i]) begin
        mm_any = 1'b1;
        mm_idx = AW'(i);
        mm_exp = shadow_q[i];
        mm_act = drv_regs[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    err_flag_d = err_flag_q;
    err_cnt_d  = err_cnt_q;
    chk_cnt_d  = chk_cnt_q;
    idx_d      = idx_q;
    exp_d      = exp_q;
    act_d      = act_q;
    if (state_q == WARMUP) begin
      wcnt_d  = wcnt_q + 1'b1;
      state_d = (wcnt_q == WW'(CMP_LAT - 1)) ? CHECK : WARMUP;
    end else if (i_chk_en) begin
      chk_cnt_d = (chk_cnt_q == '1) ? chk_cnt_q : chk_cnt_q + 1'b1;
      if (mm_any) begin
        err_cnt_d  = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;
        err_flag_d = 1'b1;
        state_d    = FAIL;
        idx_d      = (state_q == CHECK) ? mm_idx : idx_q;
        exp_d      = (state_q == CHECK) ? mm_exp : exp_q;
        act_d      = (state_q == CHECK) ? mm_act : act_q;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= WARMUP;
      wcnt_q     <= '0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
      chk_cnt_q  <= '0;
      idx_q      <= '0;
      exp_q      <= '0;
      act_q      <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
      chk_cnt_q  <= chk_cnt_d;
      idx_q      <= idx_d;
      exp_q      <= exp_d;
      act_q      <= act_d;
    end
  end

  assign o_err_flag      = err_flag_q;
  assign o_err_cnt       = err_cnt_q;
  assign o_chk_cnt       = chk_cnt_q;
  assign o_first_err_idx = idx_q;
  assign o_first_err_exp = exp_q;
  assign o_first_err_act = act_q;

`ifdef SCB_REGFILE_ASSERT_EN
  a_x0_zero: assert property (@(posedge i_clk) disable iff (!i_rst_n || state_q == WARMUP)
    drv_regs[0] == '0)
    else $error("%0t: x0 nonzero idx 0 exp 0 act %h", $time, drv_regs[0]);
  a_no_mm: assert property (@(posedge i_clk) disable iff (!i_rst_n || state_q == WARMUP)
    i_chk_en |-> !mm_any)
    else $error("%0t: regfile mismatch idx %0d exp %h act %h", $time, mm_idx, mm_exp, mm_act);
`endif
endmodule
